// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run monitor.
//   state_e         : FSM state encodings (IDLE/RUN/DONE/TMO)
//   FINISH_ADDR_DEF : default data address whose store ends a run
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam logic [31:0] FINISH_ADDR_DEF = 32'h0000_7fff;

endpackage

// File: rtl/run_monitor_ckpt_counter.sv
// One programmable PC checkpoint with its saturating hit counter.
//   clk, rst          : clock, async active-high reset
//   cfg_we/idx/addr/en: config write; applied only when cfg_idx selects IDX
//   pc, pc_valid      : retire snoop
//   clear             : zero the hit count (start of a run)
//   freeze            : hold the hit count (not running)
//   count             : hit count, saturates at all-ones
module ckpt_counter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 2,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              clear,
  input  logic              freeze,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              sel;
  logic              hit;

  // Out-of-range indices never match any instance, so they are dropped.
  assign sel = cfg_we && (cfg_idx == IDX_W'(IDX));
  assign hit = !freeze && pc_valid && en && (pc == addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      en    <= 1'b0;
      count <= '0;
    end else begin
      if (sel) begin
        addr <= cfg_addr;
        en   <= cfg_en;
      end
      if (clear)
        count <= '0;
      else if (hit && (count != '1))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run monitor for the mipse core: snoops retire PC and the data store port,
// counts RUN cycles and per-checkpoint PC hits, detects the finish store.
// Optional watchdog: define RUN_MON_WATCHDOG_EN to add the TMO state.
//   clk, rst      : clock, async active-high reset
//   start         : begin/restart a run (ignored while running)
//   pc, pc_valid  : retire snoop
//   daddr, wdata, memwrite : store snoop
//   cfg_*         : checkpoint configuration write
//   running/done/timeout   : state flags
//   cycle_cnt     : RUN cycles, saturating
//   hit_cnt       : per-checkpoint hits, index i at [i*CNT_W +: CNT_W]
//   exit_code     : wdata of the finish store
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                N_CKPT      = 4,
  parameter int                CNT_W       = 32,
  parameter logic [ADDR_W-1:0] FINISH_ADDR = ADDR_W'(FINISH_ADDR_DEF),
  parameter int unsigned       TIMEOUT     = 10000000,
  localparam int               IDX_W       = (N_CKPT > 1) ? $clog2(N_CKPT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       pc,
  input  logic                    pc_valid,
  input  logic [ADDR_W-1:0]       daddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    memwrite,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic                    cfg_en,
  output logic                    running,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [N_CKPT*CNT_W-1:0] hit_cnt,
  output logic [DATA_W-1:0]       exit_code
);

  state_e state_q, state_d;
  logic   start_acc;
  logic   finish;
  logic   wdog;

  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign start_acc = start && !running;
  assign finish    = running && memwrite && (daddr == FINISH_ADDR);

`ifdef RUN_MON_WATCHDOG_EN
  // Finish takes priority over a watchdog expiry in the same cycle.
  assign wdog    = running && (64'(cycle_cnt) == (64'(TIMEOUT) - 64'd1)) && !finish;
  assign timeout = (state_q == ST_TMO);
`else
  assign wdog    = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (finish)    state_d = ST_DONE;
        else if (wdog) state_d = ST_TMO;
      end
      default: begin
        if (start) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      exit_code <= '0;
    end else if (start_acc) begin
      cycle_cnt <= '0;
      exit_code <= '0;
    end else if (running) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (finish)          exit_code <= wdata;
    end
  end

  for (genvar i = 0; i < N_CKPT; i++) begin : g_ckpt
    ckpt_counter #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .IDX_W  (IDX_W),
      .IDX    (i)
    ) u_ckpt (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_addr (cfg_addr),
      .cfg_en   (cfg_en),
      .pc       (pc),
      .pc_valid (pc_valid),
      .clear    (start_acc),
      .freeze   (!running),
      .count    (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor. Three instances share all inputs:
//   dut   : 32-bit counters, long watchdog
//   dut_s : 4-bit counters (saturation)
//   dut_w : watchdog limit 20 (only active with RUN_MON_WATCHDOG_EN)
module tb_run_monitor;

  localparam int NC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pc_valid, memwrite, cfg_we, cfg_en;
  logic [31:0] pc, daddr, wdata, cfg_addr;
  logic [1:0]  cfg_idx;

  logic        run_a, done_a, tmo_a;
  logic [31:0] cyc_a, exit_a;
  logic [NC*32-1:0] hit_a;

  logic        run_s, done_s, tmo_s;
  logic [3:0]  cyc_s;
  logic [31:0] exit_s;
  logic [NC*4-1:0] hit_s;

  logic        run_w, done_w, tmo_w;
  logic [31:0] cyc_w, exit_w;
  logic [NC*32-1:0] hit_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_monitor #(.N_CKPT(NC), .CNT_W(32), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
    .daddr(daddr), .wdata(wdata), .memwrite(memwrite), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .running(run_a), .done(done_a), .timeout(tmo_a), .cycle_cnt(cyc_a),
    .hit_cnt(hit_a), .exit_code(exit_a));

  run_monitor #(.N_CKPT(NC), .CNT_W(4), .TIMEOUT(1000)) dut_s (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
    .daddr(daddr), .wdata(wdata), .memwrite(memwrite), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .running(run_s), .done(done_s), .timeout(tmo_s), .cycle_cnt(cyc_s),
    .hit_cnt(hit_s), .exit_code(exit_s));

  run_monitor #(.N_CKPT(NC), .CNT_W(32), .TIMEOUT(20)) dut_w (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
    .daddr(daddr), .wdata(wdata), .memwrite(memwrite), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .running(run_w), .done(done_w), .timeout(tmo_w), .cycle_cnt(cyc_w),
    .hit_cnt(hit_w), .exit_code(exit_w));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic e);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_en = e;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] hit(input int i);
    return hit_a[i*32 +: 32];
  endfunction

  initial begin
    logic vseq [11] = '{1,1,0,1,1,1,0,1,0,1,1};
    rst = 1'b1; start = 0; pc = 0; pc_valid = 0; daddr = 0; wdata = 0;
    memwrite = 0; cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_en = 0;
    tick(2);
    chk("rst_running", run_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_timeout", tmo_a, 0);
    chk("rst_cycle", cyc_a, 0);
    chk("rst_hits", hit_a, 0);
    chk("rst_exit", exit_a, 0);
    rst = 1'b0;
    tick();

    // Run then abort with reset at RUN cycle 50.
    pulse_start();
    chk("start_running", run_a, 1);
    chk("start_cycle0", cyc_a, 0);
    tick(20);
    chk("cyc20", cyc_a, 20);
    chk("sat_cyc15", cyc_s, 15);
    chk("sat_running", run_s, 1);
`ifdef RUN_MON_WATCHDOG_EN
    chk("wdog_timeout", tmo_w, 1);
    chk("wdog_running", run_w, 0);
    chk("wdog_cyc", cyc_w, 20);
    tick(3);
    chk("wdog_sticky", tmo_w, 1);
    chk("wdog_frozen", cyc_w, 20);
    tick(27);
`else
    chk("nowdog_timeout", tmo_w, 0);
    chk("nowdog_running", run_w, 1);
    tick(30);
`endif
    chk("cyc50", cyc_a, 50);
    rst = 1'b1;
    #1;
    chk("async_rst_running", run_a, 0);
    chk("async_rst_cycle", cyc_a, 0);
    chk("async_rst_done", done_a, 0);
    chk("async_rst_timeout", tmo_w, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_rst", run_a, 0);

    // Checkpoint 0 with stalls, then finish store at RUN cycle 100.
    cfg(2'd0, 32'h30, 1'b1);
    pc = 32'h30;
    pulse_start();
    for (int k = 0; k < 11; k++) begin
      pc_valid = vseq[k];
      memwrite = (k == 0); daddr = 32'h7ffe; wdata = 32'h55;
      tick();
    end
    pc_valid = 0; memwrite = 0;
    chk("near_addr_no_finish", run_a, 1);
    chk("ckpt0_hits8", hit(0), 8);
    chk("ckpt1_hits0", hit(1), 0);
    chk("cyc11", cyc_a, 11);
    tick(89);
    chk("cyc100", cyc_a, 100);
    memwrite = 1; daddr = 32'h7fff; wdata = 32'h2A;
    tick();
    chk("fin_done", done_a, 1);
    chk("fin_running", run_a, 0);
    chk("fin_exit", exit_a, 32'h2A);
    chk("fin_cyc101", cyc_a, 101);
    pc_valid = 1; wdata = 32'h99;
    tick(3);
    pc_valid = 0; memwrite = 0;
    chk("frozen_cyc", cyc_a, 101);
    chk("frozen_hits", hit(0), 8);
    chk("frozen_exit", exit_a, 32'h2A);
    chk("frozen_done", done_a, 1);

    // Finish on RUN cycle 20: beats the watchdog on dut_w.
    pulse_start();
    tick(19);
    memwrite = 1; daddr = 32'h7fff; wdata = 32'h11;
    tick();
    memwrite = 0;
    chk("tie_done", done_w, 1);
    chk("tie_timeout", tmo_w, 0);
    chk("tie_cyc20", cyc_a, 20);
    chk("tie_exit", exit_a, 32'h11);

    // Overlapping checkpoints, restart from DONE.
    cfg(2'd0, 32'h40, 1'b1);
    cfg(2'd1, 32'h40, 1'b1);
    cfg(2'd2, 32'h40, 1'b0);
    chk("cfg_in_done_keeps", done_a, 1);
    pulse_start();
    chk("restart_running", run_a, 1);
    chk("restart_cyc", cyc_a, 0);
    chk("restart_exit", exit_a, 0);
    chk("restart_done", done_a, 0);
    pc = 32'h40; pc_valid = 1;
    tick(5);
    pc_valid = 0;
    chk("multi_h0", hit(0), 5);
    chk("multi_h1", hit(1), 5);
    chk("multi_h2", hit(2), 0);
    cfg(2'd3, 32'h50, 1'b1);
    pc = 32'h50; pc_valid = 1;
    tick(2);
    chk("badidx_h0", hit(0), 5);
    chk("badidx_h2", hit(2), 0);
    pc = 32'h40;
    tick();
    chk("badidx_addr_kept", hit(0), 6);
    start = 1;
    tick();
    start = 0;
    chk("start_in_run_cyc", cyc_a, 10);
    chk("start_in_run_h1", hit(1), 7);
    cfg_we = 1; cfg_idx = 2'd2; cfg_addr = 32'h40; cfg_en = 1;
    tick();
    cfg_we = 0;
    chk("cfg_run_not_yet", hit(2), 0);
    chk("cfg_run_h0", hit(0), 8);
    tick();
    pc_valid = 0;
    chk("cfg_run_effective", hit(2), 1);
    chk("cfg_run_h1", hit(1), 9);
    chk("sat_hit", hit_s[0 +: 4], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
